// File: rtl/myproject_mul_pipe_12s_8ns_19.sv
// Pipelined din0*din1 multiplier: per-operand signedness, arithmetic rescale and saturate-or-wrap.
// Latency NUM_STAGE-1 edges after acceptance; stalls freeze every stage while dout is held.
module myproject_mul_pipe_12s_8ns_19 #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 12,
  parameter int din1_WIDTH  = 8,
  parameter int dout_WIDTH  = 19,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int SAT         = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_ovf
);

  localparam int P  = din0_WIDTH + din1_WIDTH + 2;
  localparam int WX = (P > dout_WIDTH) ? P : dout_WIDTH;

  logic                adv;
  logic signed [P-1:0] fin_prod;
  logic                fin_v;

  // A single global enable: the whole pipe moves only when the output slot frees up.
  assign adv       = !dout_valid | dout_ready;
  assign din_ready = adv;

  function automatic logic signed [P-1:0] mul_ext(input logic [din0_WIDTH-1:0] a,
                                                  input logic [din1_WIDTH-1:0] b);
    logic                sa;
    logic                sb;
    logic signed [P-1:0] ax;
    logic signed [P-1:0] bx;
    sa = (DIN0_SIGNED != 0) & a[din0_WIDTH-1];
    sb = (DIN1_SIGNED != 0) & b[din1_WIDTH-1];
    ax = {{(P-din0_WIDTH){sa}}, a};
    bx = {{(P-din1_WIDTH){sb}}, b};
    return ax * bx;
  endfunction

  // Returns {ovf, result}; overflow means the shifted value does not fit the signed dout range.
  function automatic logic [dout_WIDTH:0] narrow(input logic signed [P-1:0] p);
    logic signed [P-1:0]        s;
    logic signed [WX-1:0]       sx;
    logic [WX-dout_WIDTH:0]     hi;
    logic                       ovf;
    logic [dout_WIDTH-1:0]      lo;
    s   = p >>> SHIFT;
    sx  = WX'(s);
    hi  = sx[WX-1:dout_WIDTH-1];
    ovf = !((&hi) | ~(|hi));
    lo  = sx[dout_WIDTH-1:0];
    if (SAT != 0 && ovf)
      lo = sx[WX-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
    return {ovf, lo};
  endfunction

  generate
    if (NUM_STAGE == 1) begin : g_s1
      assign fin_prod = mul_ext(din0, din1);
      assign fin_v    = din_valid;
    end else begin : g_sn
      logic [din0_WIDTH-1:0] a_q;
      logic [din1_WIDTH-1:0] b_q;
      logic                  v1_q;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          a_q  <= '0;
          b_q  <= '0;
          v1_q <= 1'b0;
        end else if (adv) begin
          a_q  <= din0;
          b_q  <= din1;
          v1_q <= din_valid;
        end
      end

      if (NUM_STAGE == 2) begin : g_direct
        assign fin_prod = mul_ext(a_q, b_q);
        assign fin_v    = v1_q;
      end else begin : g_prod
        logic signed [P-1:0]  p_q [2:NUM_STAGE-1];
        logic [NUM_STAGE-1:2] v_q;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
          if (!ap_rst_n) begin
            for (int s = 2; s < NUM_STAGE; s++) p_q[s] <= '0;
            v_q <= '0;
          end else if (adv) begin
            p_q[2] <= mul_ext(a_q, b_q);
            v_q[2] <= v1_q;
            for (int s = 3; s < NUM_STAGE; s++) begin
              p_q[s] <= p_q[s-1];
              v_q[s] <= v_q[s-1];
            end
          end
        end

        assign fin_prod = p_q[NUM_STAGE-1];
        assign fin_v    = v_q[NUM_STAGE-1];
      end
    end
  endgenerate

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ovf   <= 1'b0;
    end else if (adv) begin
      dout_valid       <= fin_v;
      {dout_ovf, dout} <= narrow(fin_prod);
    end
  end

endmodule
